// File: rtl/stepper_pkg.sv
// -----------------------------------------------------------------------------
// stepper_pkg
//   Shared definitions for the stepper phase sequencer:
//     - state_e      : sequencer FSM states (IDLE, RUN, HOLD)
//     - PHASE_TABLE  : 8-entry half-step coil table, indexed by the phase index
//     - *_B / SPEED_*: bit positions inside the PIO control byte
//     - step_period(): step period in base ticks for a given speed code
// -----------------------------------------------------------------------------
package stepper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Coil pattern {A,B,C,D}; entry 0 is the rightmost element.
    // Even entries energize one coil, odd entries energize two adjacent coils.
    localparam logic [7:0][3:0] PHASE_TABLE = {
        4'b1001,  // 7
        4'b0001,  // 6
        4'b0011,  // 5
        4'b0010,  // 4
        4'b0110,  // 3
        4'b0100,  // 2
        4'b1100,  // 1
        4'b1000   // 0
    };

    localparam int RUN_B     = 0;
    localparam int DIR_B     = 1;
    localparam int HALF_B    = 2;
    localparam int SPEED_LSB = 3;
    localparam int SPEED_MSB = 7;

    // Step period in base ticks: speed 31 -> 1 tick, speed 0 -> 32 ticks.
    function automatic logic [5:0] step_period(input logic [4:0] speed);
        return 6'd32 - {1'b0, speed};
    endfunction

endpackage

// File: rtl/stepper_phase_sequencer_tick_gen.sv
// -----------------------------------------------------------------------------
// stepper_tick_gen
//   Free-running prescaler producing the base tick of the sequencer. The count
//   runs 0..TICK_DIV-1 and tick_o is high while the count equals TICK_DIV-1.
//   clear_i restarts the count at 0 on the next edge so that a new period or
//   hold interval always starts with a full tick.
//
//   Ports:
//     clk      in   clock
//     reset_n  in   asynchronous active-low reset
//     clear_i  in   synchronous prescaler clear
//     tick_o   out  base tick, one clock wide every TICK_DIV clocks
// -----------------------------------------------------------------------------
module stepper_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick_o = (cnt_q == CW'(TICK_DIV - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/stepper_phase_sequencer.sv
// -----------------------------------------------------------------------------
// stepper_phase_sequencer
//   Turns the PIO control byte into a timed 4-coil stepper phase sequence with
//   full/half-step patterns, direction, programmable rate and a timed
//   hold-then-release power state. Keeps a wrapping signed position count.
//
//   Ports:
//     clk         in   clock (same domain as the PIO)
//     reset_n     in   asynchronous active-low reset
//     ctrl[7:0]   in   {speed[4:0], half, dir, run}
//     coils[3:0]  out  coil drive {A,B,C,D}, registered
//     step_pulse  out  one-clock pulse per executed step, registered
//     busy        out  high whenever the sequencer is not idle, registered
//     position    out  signed step count, wraps modulo 2^16, registered
// -----------------------------------------------------------------------------
module stepper_phase_sequencer
    import stepper_pkg::*;
#(
    parameter int TICK_DIV   = 50000,
    parameter int HOLD_TICKS = 200
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  ctrl,
    output logic [3:0]  coils,
    output logic        step_pulse,
    output logic        busy,
    output logic [15:0] position
);

    localparam int HW = $clog2(HOLD_TICKS + 1);

    logic       run;
    logic       dir;
    logic       half;
    logic [4:0] speed;
    logic [5:0] period;

    assign run    = ctrl[RUN_B];
    assign dir    = ctrl[DIR_B];
    assign half   = ctrl[HALF_B];
    assign speed  = ctrl[SPEED_MSB:SPEED_LSB];
    assign period = step_period(speed);

    state_e        state_q;
    logic [5:0]    timer_q;
    logic [HW-1:0] hold_q;
    logic [2:0]    idx_q;
    logic [15:0]   pos_q;
    logic [3:0]    coils_q;
    logic          pulse_q;
    logic          busy_q;

    logic tick;
    logic presc_clr;
    logic step_due;

    // The prescaler restarts on every RUN entry and on HOLD entry, so the
    // first period / hold interval is always a whole number of ticks.
    assign presc_clr = ((state_q == ST_IDLE) &&  run) ||
                       ((state_q == ST_HOLD) &&  run) ||
                       ((state_q == ST_RUN)  && !run);

    assign step_due = (state_q == ST_RUN) && tick && (timer_q == 6'd1);

    stepper_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (presc_clr),
        .tick_o  (tick)
    );

    // Next phase index: full-step from an odd entry jumps two entries to the
    // next two-coil pattern; from an even entry it moves one to realign.
    logic [2:0] idx_inc;
    logic [2:0] idx_d;

    // NOTE: every signal driven here gets a value on every path, so no latch
    // is inferred.
    always_comb begin
        idx_inc = (half || !idx_q[0]) ? 3'd1 : 3'd2;
        idx_d   = dir ? (idx_q + idx_inc) : (idx_q - idx_inc);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            hold_q  <= '0;
            idx_q   <= '0;
            pos_q   <= '0;
            coils_q <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_q <= ST_RUN;
                        timer_q <= period;
                        coils_q <= PHASE_TABLE[idx_q];
                        busy_q  <= 1'b1;
                    end
                end

                ST_RUN: begin
                    if (step_due) begin
                        idx_q   <= idx_d;
                        pos_q   <= pos_q + (dir ? 16'd1 : 16'hFFFF);
                        coils_q <= PHASE_TABLE[idx_d];
                        pulse_q <= 1'b1;
                        timer_q <= period;
                    end else if (tick) begin
                        timer_q <= timer_q - 6'd1;
                    end
                    // A step due on the same edge still executes above;
                    // the partial period is simply dropped.
                    if (!run) begin
                        state_q <= ST_HOLD;
                        hold_q  <= HW'(HOLD_TICKS);
                    end
                end

                ST_HOLD: begin
                    if (run) begin
                        state_q <= ST_RUN;
                        timer_q <= period;
                    end else if (tick) begin
                        hold_q <= hold_q - 1'b1;
                        if (hold_q == HW'(1)) begin
                            state_q <= ST_IDLE;
                            coils_q <= 4'b0000;
                            busy_q  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    coils_q <= 4'b0000;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign coils      = coils_q;
    assign step_pulse = pulse_q;
    assign busy       = busy_q;
    assign position   = pos_q;

endmodule

// File: tb/tb_stepper_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stepper_phase_sequencer
//   Directed vector table, hand-written corner sequences and a randomized run
//   compared against a clock-countdown reference model. A second instance with
//   a shorter tick divider covers the 16-bit position wrap.
// -----------------------------------------------------------------------------
module tb_stepper_phase_sequencer;

    localparam int TD = 4;
    localparam int HT = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  ctrl = 8'h00;
    logic [3:0]  coils;
    logic        step_pulse;
    logic        busy;
    logic [15:0] position;

    logic [7:0]  ctrl_f = 8'h00;
    logic [3:0]  coils_f;
    logic        step_pulse_f;
    logic        busy_f;
    logic [15:0] position_f;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    stepper_phase_sequencer #(.TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ctrl       (ctrl),
        .coils      (coils),
        .step_pulse (step_pulse),
        .busy       (busy),
        .position   (position)
    );

    stepper_phase_sequencer #(.TICK_DIV(2), .HOLD_TICKS(HT)) dut_fast (
        .clk        (clk),
        .reset_n    (reset_n),
        .ctrl       (ctrl_f),
        .coils      (coils_f),
        .step_pulse (step_pulse_f),
        .busy       (busy_f),
        .position   (position_f)
    );

    // Bench copy of the coil table.
    logic [3:0] pat [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                            4'b0010, 4'b0011, 4'b0001, 4'b1001};

    // ---------------- reference model: counts clocks, not ticks -------------
    int          m_mode;   // 0 idle, 1 running, 2 holding
    int          m_idx;
    int          m_cnt;    // clocks left in the current period / hold
    logic [15:0] m_pos;
    logic        m_pulse;

    function automatic int next_idx(input int i, input logic d, input logic h);
        int s;
        s = (h || (i % 2 == 0)) ? 1 : 2;
        return d ? (i + s) % 8 : (i + 8 - s) % 8;
    endfunction

    function automatic int period_clocks(input logic [7:0] c);
        return (32 - int'(c[7:3])) * TD;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode  <= 0;
            m_idx   <= 0;
            m_cnt   <= 0;
            m_pos   <= 16'h0000;
            m_pulse <= 1'b0;
        end else begin
            m_pulse <= 1'b0;
            case (m_mode)
                0: if (ctrl[0]) begin
                    m_mode <= 1;
                    m_cnt  <= period_clocks(ctrl);
                end
                1: begin
                    if (m_cnt == 1) begin
                        m_idx   <= next_idx(m_idx, ctrl[1], ctrl[2]);
                        m_pos   <= m_pos + (ctrl[1] ? 16'd1 : 16'hFFFF);
                        m_pulse <= 1'b1;
                        m_cnt   <= period_clocks(ctrl);
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                    if (!ctrl[0]) begin
                        m_mode <= 2;
                        m_cnt  <= HT * TD;
                    end
                end
                default: begin
                    if (ctrl[0]) begin
                        m_mode <= 1;
                        m_cnt  <= period_clocks(ctrl);
                    end else begin
                        m_cnt <= m_cnt - 1;
                        if (m_cnt == 1) m_mode <= 0;
                    end
                end
            endcase
        end
    end

    // ---------------- helpers ------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance n active edges and land 1 time unit after the last one.
    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ctrl    = 8'h00;
        #12;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic check_out(input string name, input logic [3:0] c, input logic p,
                             input logic b, input logic [15:0] pos);
        check({name, ".coils"}, 32'(coils), 32'(c));
        check({name, ".pulse"}, 32'(step_pulse), 32'(p));
        check({name, ".busy"}, 32'(busy), 32'(b));
        check({name, ".pos"}, 32'(position), 32'(pos));
    endtask

    typedef struct {
        string       name;
        logic [7:0]  ctrl;
        int          clks;
        logic [3:0]  coils;
        logic        pulse;
        logic        busy;
        logic [15:0] pos;
    } vec_t;

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{"fwd_entry", 8'hFB, 1, 4'b1000, 1'b0, 1'b1, 16'h0000};
        vecs[1]  = '{"fwd_s1",    8'hFB, 4, 4'b1100, 1'b1, 1'b1, 16'h0001};
        vecs[2]  = '{"fwd_s2",    8'hFB, 4, 4'b0110, 1'b1, 1'b1, 16'h0002};
        vecs[3]  = '{"fwd_s3",    8'hFB, 4, 4'b0011, 1'b1, 1'b1, 16'h0003};
        vecs[4]  = '{"fwd_s4",    8'hFB, 4, 4'b1001, 1'b1, 1'b1, 16'h0004};
        vecs[5]  = '{"fwd_s5",    8'hFB, 4, 4'b1100, 1'b1, 1'b1, 16'h0005};
        vecs[6]  = '{"fwd_gap",   8'hFB, 1, 4'b1100, 1'b0, 1'b1, 16'h0005};
        vecs[7]  = '{"rev_entry", 8'hF5, 1, 4'b1000, 1'b0, 1'b1, 16'h0000};
        vecs[8]  = '{"rev_s1",    8'hF5, 8, 4'b1001, 1'b1, 1'b1, 16'hFFFF};
        vecs[9]  = '{"rev_s2",    8'hF5, 8, 4'b0001, 1'b1, 1'b1, 16'hFFFE};
        vecs[10] = '{"rev_s3",    8'hF5, 8, 4'b0011, 1'b1, 1'b1, 16'hFFFD};

        // ---- reset state ----
        #3;
        check_out("reset_state", 4'b0000, 1'b0, 1'b0, 16'h0000);
        do_reset();
        check_out("post_reset", 4'b0000, 1'b0, 1'b0, 16'h0000);

        // ---- full-step forward ----
        for (int i = 0; i < 7; i++) begin
            ctrl = vecs[i].ctrl;
            clocks(vecs[i].clks);
            check_out(vecs[i].name, vecs[i].coils, vecs[i].pulse, vecs[i].busy, vecs[i].pos);
        end

        // ---- asynchronous reset mid-run: outputs clear with no clock edge ----
        #2;
        reset_n = 1'b0;
        #1;
        check_out("async_reset", 4'b0000, 1'b0, 1'b0, 16'h0000);
        ctrl = 8'h00;
        @(negedge clk);
        reset_n = 1'b1;

        // ---- half-step reverse ----
        for (int i = 7; i < 11; i++) begin
            ctrl = vecs[i].ctrl;
            clocks(vecs[i].clks);
            check_out(vecs[i].name, vecs[i].coils, vecs[i].pulse, vecs[i].busy, vecs[i].pos);
        end

        // ---- run drop mid-period, hold for HT*TD clocks, then release ----
        clocks(3);
        ctrl = 8'hF4;
        clocks(1);
        check_out("hold_entry", 4'b0011, 1'b0, 1'b1, 16'hFFFD);
        for (int i = 1; i < HT * TD; i++) begin
            clocks(1);
            check("hold_coils", 32'(coils), 32'(4'b0011));
            check("hold_pulse", 32'(step_pulse), 32'd0);
        end
        clocks(1);
        check_out("hold_release", 4'b0000, 1'b0, 1'b0, 16'hFFFD);

        // ---- re-raise run during HOLD ----
        ctrl = 8'hF5;
        clocks(1);
        check_out("rerun_entry", 4'b0011, 1'b0, 1'b1, 16'hFFFD);
        clocks(2);
        ctrl = 8'hF4;
        clocks(3);
        check_out("rerun_hold", 4'b0011, 1'b0, 1'b1, 16'hFFFD);
        ctrl = 8'hF5;
        clocks(1);
        check_out("rerun_resume", 4'b0011, 1'b0, 1'b1, 16'hFFFD);
        for (int i = 1; i < 8; i++) begin
            clocks(1);
            check("rerun_coils", 32'(coils), 32'(4'b0011));
            check("rerun_pulse", 32'(step_pulse), 32'd0);
        end
        clocks(1);
        check_out("rerun_step", 4'b0010, 1'b1, 1'b1, 16'hFFFC);

        // ---- speed 31 -> 0 mid-run: old period completes, then 128 clocks ----
        do_reset();
        ctrl = 8'hFB;
        clocks(1);
        ctrl = 8'h03;
        clocks(3);
        check_out("spd_before", 4'b1000, 1'b0, 1'b1, 16'h0000);
        clocks(1);
        check_out("spd_old_step", 4'b1100, 1'b1, 1'b1, 16'h0001);
        clocks(127);
        check_out("spd_wait", 4'b1100, 1'b0, 1'b1, 16'h0001);
        clocks(1);
        check_out("spd_new_step", 4'b0110, 1'b1, 1'b1, 16'h0002);

        // ---- run falls on the step edge: step executes, then HOLD ----
        do_reset();
        ctrl = 8'hFB;
        clocks(4);
        ctrl = 8'hFA;
        clocks(1);
        check_out("fall_step", 4'b1100, 1'b1, 1'b1, 16'h0001);
        clocks(HT * TD - 1);
        check_out("fall_hold", 4'b1100, 1'b0, 1'b1, 16'h0001);
        clocks(1);
        check_out("fall_idle", 4'b0000, 1'b0, 1'b0, 16'h0001);

        // ---- randomized run against the reference model ----
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            check("rnd_coils", 32'(coils), 32'((m_mode == 0) ? 4'b0000 : pat[m_idx]));
            check("rnd_pulse", 32'(step_pulse), 32'(m_pulse));
            check("rnd_busy", 32'(busy), 32'(m_mode != 0));
            check("rnd_pos", 32'(position), 32'(m_pos));
            if ($urandom_range(0, 15) == 0) begin
                logic [4:0] spd;
                spd  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                   : 5'($urandom_range(26, 31));
                ctrl = {spd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 4) != 0)};
            end
        end

        // ---- position wrap 7FFF -> 8000 on the fast instance (2 clocks/step) ----
        do_reset();
        ctrl_f = 8'hFB;
        clocks(1);
        clocks(2 * 32767);
        check("wrap_7fff", 32'(position_f), 32'h0000_7FFF);
        check("wrap_pulse", 32'(step_pulse_f), 32'd1);
        clocks(2);
        check("wrap_8000", 32'(position_f), 32'h0000_8000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/stepper_phase_sequencer.md
# stepper_phase_sequencer

Converts the 8-bit control byte from the Avalon PIO output register into a timed 4-coil phase sequence for a unipolar/bipolar stepper driver stage. It sits directly downstream of the PIO: `ctrl` is wired to the PIO's `out_port`. It generates the step rate, the direction and the full/half-step pattern, and manages a hold-then-release power state. It also maintains a wrapping position counter for software or debug readback.

## Interface
Parameters:
- `TICK_DIV`, default 50000: clocks per base tick; must be ≥2.
- `HOLD_TICKS`, default 200: ticks the coils stay energized after `run` drops; must be ≥1.

Ports:
- `clk`, in, 1: clock.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `ctrl`, in, 8: control byte from the PIO.
  - [0] `run`.
  - [1] `dir` (1 = forward).
  - [2] `half` (1 = half-step).
  - [7:3] `speed` (0–31).
- `coils`, out, 4: coil drive pattern A, B, C, D = bits [3:0].
- `step_pulse`, out, 1: one-clock pulse per executed step.
- `busy`, out, 1: state ≠ IDLE.
- `position`, out, 16: signed step count; wraps modulo 2^16.

## Operation
- Same clock domain as the PIO; no synchronizer. `ctrl` is sampled every clock.
- Step period P = 32 − `speed` ticks (range 1..32). `speed` = 31 is the fastest.
- Phase index `idx` is 3 bits and selects the 8-entry half-step table:
  - 0: 1000
  - 1: 1100
  - 2: 0100
  - 3: 0110
  - 4: 0010
  - 5: 0011
  - 6: 0001
  - 7: 1001
- Step rule, with all `idx` arithmetic modulo 8:
  - `half` = 1: `idx` ± 1.
  - `half` = 0 and `idx` odd: `idx` ± 2.
  - `half` = 0 and `idx` even: `idx` ± 1, which lands on an odd two-phase-on entry.
  - `position` changes by ±1 per step, regardless of step size.
- `dir`, `half` and `speed` are sampled only at a step instant. P is re-sampled at every timer reload, so a changed `speed` takes effect on the next period.
- FSM:
  - **IDLE**
    - `coils` = 0000.
    - `run` = 1 → RUN: clear prescaler, load timer with P.
  - **RUN**
    - `coils` = table[`idx`].
    - When a tick occurs with timer = 1, execute the step and reload timer with P. Otherwise a tick decrements the timer.
    - `run` = 0 → HOLD: load the hold counter with HOLD_TICKS. The partial period is discarded.
  - **HOLD**
    - `coils` = table[`idx`].
    - The hold counter decrements on each tick; reaching 0 → IDLE.
    - `run` = 1 → RUN: clear prescaler, load timer with P. The coils stay energized and do not glitch.
- A step and a `run` fall in the same cycle: the step executes, then the FSM enters HOLD.
- Reset values, all asynchronous:
  - state = IDLE.
  - `coils` = 0000.
  - `idx` = 0.
  - `position` = 0.
  - `step_pulse` = 0.
  - `busy` = 0.
  - prescaler = 0; timer = 0; hold counter = 0.
- Reset mid-run aborts immediately with no completion of the current step.

## Timing
- All outputs are registered.
- Prescaler: counts 0..TICK_DIV−1. `tick` is asserted on the clock at which the count equals TICK_DIV−1.
- Entry timing: `run` is sampled high at edge N.
  - State becomes RUN after edge N.
  - `coils` = table[`idx`] from the cycle after edge N.
  - First `step_pulse` and the `idx`/`position` update occur exactly P·TICK_DIV clocks later.
- Steady state: steps repeat every P·TICK_DIV clocks with constant P.
- `step_pulse` is high for exactly 1 clock. It is coincident with the new `coils`/`position` values.
- `run` fall → HOLD on the next edge. IDLE (`coils` = 0) follows HOLD_TICKS·TICK_DIV clocks after the prescaler clears on HOLD entry.
- No latency from `ctrl` to `coils` beyond 1 register stage.

## Structure
- Package `stepper_pkg`:
  - FSM state enum (IDLE, RUN, HOLD).
  - 8×4 phase table constant.
  - `ctrl` bit-index constants (RUN_B, DIR_B, HALF_B, SPEED_LSB/MSB).
  - Function computing P from `speed`.
- Sub-module `stepper_tick_gen`: prescaler with synchronous clear input and a `tick` output; parameterized by TICK_DIV.
- Top level holds the FSM, step timer, hold counter, `idx` and `position` registers.

## Test plan
Bench parameters: TICK_DIV = 4, HOLD_TICKS = 3.
- **Reset:** assert `reset_n` = 0 mid-RUN. Require `coils` = 0, `position` = 0, `busy` = 0 and `step_pulse` = 0 immediately, with no clock edge needed.
- **Full-step forward:** `ctrl` = 8'hFB (`run`, `dir`, `speed` = 31, P = 1), starting at `idx` = 0.
  - Require `coils` = 1000 after entry.
  - Then, every 4 clocks, steps to 1100, 0110, 0011, 1001, 1100.
  - `position` increments 1, 2, 3, 4, 5.
- **Half-step reverse:** `ctrl` = {5'd30, 3'b101} (P = 2), starting at `idx` = 0.
  - Require steps every 8 clocks: 1001, 0001, 0011.
  - `position` = −1, −2, −3 (16'hFFFF, 16'hFFFE, 16'hFFFD).
- **Run drop / hold / release:** drop `run` mid-period.
  - Require no further `step_pulse`.
  - `coils` held for 12 clocks, then 0000 and `busy` = 0.
  - Re-raising `run` during HOLD keeps the `coils` pattern unchanged and resumes steps after P·4 clocks.
- **Boundaries:**
  - `speed` change 31 → 0 mid-run: the old period completes, then steps every 128 clocks.
  - `position` at 16'h7FFF forward: wraps to 16'h8000.
  - `run` falls on the step cycle: that step executes, then HOLD.
